// File: rtl/spi_mem_pkg.sv
// Shared types and command encodings for the SPI memory slave.
package spi_mem_pkg;

    // Frame-level controller states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        EXEC = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    // Two-bit command field carried in the top bits of every frame.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM; the array has no reset so contents survive rst_n.
module spi_mem_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Write on we, and register the addressed word every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave with on-chip RAM: frames of {cmd[1:0], payload} set the write/read
// pointers, store words, or shift a stored word back out on MISO.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic busy,
    output logic cmd_done,
    output logic frame_err
);

    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST_RX = CW'(FW - 1);
    localparam logic [CW-1:0] LAST_TX = CW'(DATA_WIDTH);

    // Pointers are sliced out of the payload, so the word must be wide enough.
    if (DATA_WIDTH < ADDR_WIDTH) begin : g_width_check
        $error("spi_mem_slave: DATA_WIDTH must be >= ADDR_WIDTH");
    end

    state_t                state_r;
    state_t                state_s;
    logic [FW-1:0]         frame_r;
    logic [CW-1:0]         bit_cnt_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  miso_r;
    logic                  busy_r;
    logic                  cmd_done_r;
    logic                  frame_err_r;
    logic [1:0]            cmd_s;
    logic [DATA_WIDTH-1:0] payload_s;
    logic                  ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_dout_s;

    // Decode the received frame and steer the RAM port (write pointer only for a data write).
    always_comb begin
        cmd_s      = frame_r[FW-1:FW-2];
        payload_s  = frame_r[DATA_WIDTH-1:0];
        ram_we_s   = (state_r == EXEC) && (cmd_s == CMD_WR_DATA);
        ram_addr_s = ram_we_s ? wr_addr_r : rd_addr_r;
    end

    spi_mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (payload_s),
        .dout (ram_dout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; SS_n high returns to IDLE from every active state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: if (!SS_n) state_s = RECV; else state_s = IDLE;
            RECV: begin
                if (SS_n)                       state_s = IDLE;
                else if (bit_cnt_r == LAST_RX)  state_s = EXEC;
                else                            state_s = RECV;
            end
            EXEC: begin
                if (SS_n)                       state_s = IDLE;
                else if (cmd_s == CMD_RD_DATA)  state_s = SEND;
                else                            state_s = DONE;
            end
            SEND: begin
                if (SS_n)                       state_s = IDLE;
                else if (bit_cnt_r == LAST_TX)  state_s = DONE;
                else                            state_s = SEND;
            end
            DONE: if (SS_n) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Shift/count datapath, pointer updates and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r     <= '0;
            bit_cnt_r   <= '0;
            wr_addr_r   <= '0;
            rd_addr_r   <= '0;
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
            cmd_done_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            busy_r      <= (state_s != IDLE);
            cmd_done_r  <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= '0;
                end
                RECV: begin
                    if (SS_n) begin
                        frame_err_r <= 1'b1;
                        bit_cnt_r   <= '0;
                    end else if (bit_cnt_r == LAST_RX) begin
                        frame_r    <= {frame_r[FW-2:0], MOSI};
                        bit_cnt_r  <= '0;
                        cmd_done_r <= 1'b1;
                    end else begin
                        frame_r   <= {frame_r[FW-2:0], MOSI};
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                EXEC: begin
                    bit_cnt_r <= '0;
                    case (cmd_s)
                        CMD_WR_ADDR: wr_addr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_WR_DATA: if (AUTO_INC) wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
                        CMD_RD_ADDR: rd_addr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_RD_DATA: if (AUTO_INC) rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
                        default:     wr_addr_r <= wr_addr_r;
                    endcase
                end
                SEND: begin
                    // First SEND edge takes the MSB straight from the RAM and parks the rest.
                    if (SS_n || (bit_cnt_r == LAST_TX)) begin
                        bit_cnt_r <= '0;
                    end else if (bit_cnt_r == '0) begin
                        miso_r                <= ram_dout_s[DATA_WIDTH-1];
                        frame_r[DATA_WIDTH-1:0] <= ram_dout_s << 1;
                        bit_cnt_r             <= bit_cnt_r + CW'(1);
                    end else begin
                        miso_r                <= frame_r[DATA_WIDTH-1];
                        frame_r[DATA_WIDTH-1:0] <= frame_r[DATA_WIDTH-1:0] << 1;
                        bit_cnt_r             <= bit_cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    bit_cnt_r <= '0;
                end
                default: begin
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    assign MISO      = miso_r;
    assign busy      = busy_r;
    assign cmd_done  = cmd_done_r;
    assign frame_err = frame_err_r;

endmodule
